// File: rtl/conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : conv_window_ctrl
// Description : Line-buffer bank sequencer for the first convolution layer.
//               Steers a raster pixel stream into KERNEL line buffers and,
//               once KERNEL rows are resident, sweeps the shared column read
//               address so every KERNEL x KERNEL window is offered to the MAC
//               array under a valid/ready handshake. Input is stalled while
//               a row of windows is being swept.
// Ports       : clk_i          - clock, all state on rising edge
//               rst_ni         - asynchronous active-low reset
//               start_i        - begin a frame (sampled in IDLE only)
//               in_valid_i     - upstream pixel available
//               in_ready_o     - controller accepting pixels
//               line_we_o      - one-hot line-buffer write enable
//               read_address_o - shared column read address (left column)
//               oldest_sel_o   - buffer holding the topmost window row
//               win_valid_o    - window on buffer outputs is valid
//               win_ready_i    - downstream consumed the window
//               out_row_o      - output row of current window
//               busy_o         - controller not idle
//               frame_done_o   - one-cycle end-of-frame pulse
// Revision    : 1.0 - initial release
// ============================================================================
module conv_window_ctrl #(
  parameter int IM_DIM = 28,
  parameter int KERNEL = 3,
  parameter int AW     = $clog2(IM_DIM),
  parameter int SW     = (KERNEL > 1) ? $clog2(KERNEL) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  output logic [KERNEL-1:0] line_we_o,
  output logic [AW-1:0]     read_address_o,
  output logic [SW-1:0]     oldest_sel_o,
  output logic              win_valid_o,
  input  logic              win_ready_i,
  output logic [AW-1:0]     out_row_o,
  output logic              busy_o,
  output logic              frame_done_o
);

  localparam int RW = $clog2(KERNEL + 1);

  localparam logic [AW-1:0] c_col_last  = AW'(IM_DIM - 1);
  localparam logic [AW-1:0] c_rd_last   = AW'(IM_DIM - KERNEL);
  localparam logic [AW-1:0] c_row_last  = AW'(IM_DIM - KERNEL);
  localparam logic [SW-1:0] c_line_last = SW'(KERNEL - 1);
  localparam logic [RW-1:0] c_rows_full = RW'(KERNEL);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_SWEEP = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t          r_state,        w_state;
  logic [AW-1:0]   r_col,          w_col;
  logic [SW-1:0]   r_wr_line,      w_wr_line;
  logic [RW-1:0]   r_rows_loaded,  w_rows_loaded;
  logic [AW-1:0]   r_read_address, w_read_address;
  logic [AW-1:0]   r_out_row,      w_out_row;
  logic [SW-1:0]   r_oldest_sel,   w_oldest_sel;
  logic            r_in_ready,     w_in_ready;
  logic            r_win_valid,    w_win_valid;
  logic            r_busy,         w_busy;
  logic            r_done,         w_done;
  logic            w_fill_hs;
  logic [KERNEL-1:0] w_line_we;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state        <= ST_IDLE;
      r_col          <= '0;
      r_wr_line      <= '0;
      r_rows_loaded  <= '0;
      r_read_address <= '0;
      r_out_row      <= '0;
      r_oldest_sel   <= '0;
      r_in_ready     <= 1'b0;
      r_win_valid    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_col          <= w_col;
      r_wr_line      <= w_wr_line;
      r_rows_loaded  <= w_rows_loaded;
      r_read_address <= w_read_address;
      r_out_row      <= w_out_row;
      r_oldest_sel   <= w_oldest_sel;
      r_in_ready     <= w_in_ready;
      r_win_valid    <= w_win_valid;
      r_busy         <= w_busy;
      r_done         <= w_done;
    end
  end

  always_comb begin
    w_state        = r_state;
    w_col          = r_col;
    w_wr_line      = r_wr_line;
    w_rows_loaded  = r_rows_loaded;
    w_read_address = r_read_address;
    w_out_row      = r_out_row;
    w_oldest_sel   = r_oldest_sel;
    // r_in_ready is high exactly in FILL, so it doubles as the state qualifier
    w_fill_hs      = in_valid_i & r_in_ready;

    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state        = ST_FILL;
          w_col          = '0;
          w_wr_line      = '0;
          w_rows_loaded  = '0;
          w_read_address = '0;
          w_out_row      = '0;
          w_oldest_sel   = '0;
        end
      end
      ST_FILL: begin
        if (w_fill_hs) begin
          if (r_col == c_col_last) begin
            w_col         = '0;
            w_wr_line     = (r_wr_line == c_line_last) ? '0 : r_wr_line + 1'b1;
            w_rows_loaded = (r_rows_loaded == c_rows_full) ? r_rows_loaded
                                                           : r_rows_loaded + 1'b1;
            if (w_rows_loaded == c_rows_full) begin
              w_state        = ST_SWEEP;
              w_read_address = '0;
            end
          end else begin
            w_col = r_col + 1'b1;
          end
        end
      end
      ST_SWEEP: begin
        if (win_ready_i) begin
          if (r_read_address == c_rd_last) begin
            if (r_out_row == c_row_last) begin
              w_state = ST_DONE;
            end else begin
              // wr_line already points at the buffer that held the oldest row
              w_out_row      = r_out_row + 1'b1;
              w_oldest_sel   = (r_oldest_sel == c_line_last) ? '0 : r_oldest_sel + 1'b1;
              w_read_address = '0;
              w_state        = ST_FILL;
            end
          end else begin
            w_read_address = r_read_address + 1'b1;
          end
        end
      end
      ST_DONE: begin
        w_state = ST_IDLE;
      end
      default: begin
        w_state = ST_IDLE;
      end
    endcase

    // Status flags are registered from the next state so they align with it
    w_in_ready  = (w_state == ST_FILL);
    w_win_valid = (w_state == ST_SWEEP);
    w_busy      = (w_state != ST_IDLE);
    w_done      = (w_state == ST_DONE);

    w_line_we = '0;
    for (int i = 0; i < KERNEL; i++) begin
      if (w_fill_hs && (r_wr_line == SW'(i))) begin
        w_line_we[i] = 1'b1;
      end
    end
  end

  assign in_ready_o     = r_in_ready;
  assign line_we_o      = w_line_we;
  assign read_address_o = r_read_address;
  assign oldest_sel_o   = r_oldest_sel;
  assign win_valid_o    = r_win_valid;
  assign out_row_o      = r_out_row;
  assign busy_o         = r_busy;
  assign frame_done_o   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_window_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_conv_window_ctrl
// Description : Self-checking bench for conv_window_ctrl. Expected pixel line
//               targets and window coordinates are queued at frame start and
//               popped as the design performs handshakes.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_conv_window_ctrl;

  localparam int IM = 28;
  localparam int K  = 3;
  localparam int AW = 5;
  localparam int SW = 2;
  localparam int NW = IM - K + 1;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          start_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          win_ready_i = 1'b0;
  logic          in_ready_o;
  logic [K-1:0]  line_we_o;
  logic [AW-1:0] read_address_o;
  logic [SW-1:0] oldest_sel_o;
  logic          win_valid_o;
  logic [AW-1:0] out_row_o;
  logic          busy_o;
  logic          frame_done_o;

  conv_window_ctrl #(.IM_DIM(IM), .KERNEL(K)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .start_i        (start_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .line_we_o      (line_we_o),
    .read_address_o (read_address_o),
    .oldest_sel_o   (oldest_sel_o),
    .win_valid_o    (win_valid_o),
    .win_ready_i    (win_ready_i),
    .out_row_o      (out_row_o),
    .busy_o         (busy_o),
    .frame_done_o   (frame_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] row;
    logic [AW-1:0] addr;
    logic [SW-1:0] sel;
  } win_t;

  int   errors = 0;
  int   checks = 0;
  win_t win_q[$];
  int   line_q[$];
  int   pix_cnt, win_cnt, done_cnt;
  bit   mon_en = 1'b0;
  bit   prev_stall = 1'b0;
  win_t prev_win, cur_win, exp_win;
  int   exp_line;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Monitor: samples on the falling edge, pops the scoreboards
  always @(negedge clk_i) begin
    if (mon_en && rst_ni) begin
      cur_win = {out_row_o, read_address_o, oldest_sel_o};
      if (prev_stall) begin
        check("stall_valid", 32'(win_valid_o), 32'd1);
        check("stall_window", 32'(cur_win), 32'(prev_win));
      end
      if (in_valid_i && in_ready_o) begin
        if (line_q.size() == 0) begin
          check("pixel_extra", 32'(pix_cnt), 32'(IM * IM));
        end else begin
          exp_line = line_q.pop_front();
          check("line_we", 32'(line_we_o), 32'(1 << exp_line));
        end
        // a new row (beyond the first KERNEL) starts only after one full row of windows per row
        if (pix_cnt % IM == 0)
          check("row_order", 32'(win_cnt),
                32'((pix_cnt / IM >= K) ? (pix_cnt / IM - K + 1) * NW : 0));
        pix_cnt++;
      end else begin
        check("line_we_idle", 32'(line_we_o), 32'd0);
      end
      if (win_valid_o && win_ready_i) begin
        if (win_q.size() == 0) begin
          check("window_extra", 32'(win_cnt), 32'(NW * NW));
        end else begin
          exp_win = win_q.pop_front();
          check("window", 32'(cur_win), 32'(exp_win));
        end
        win_cnt++;
      end
      if (frame_done_o) done_cnt++;
      prev_stall = win_valid_o && !win_ready_i;
      prev_win   = cur_win;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  32'(in_ready_o),     32'd0);
    check({tag, "_line_we"},   32'(line_we_o),      32'd0);
    check({tag, "_rd_addr"},   32'(read_address_o), 32'd0);
    check({tag, "_oldest"},    32'(oldest_sel_o),   32'd0);
    check({tag, "_win_valid"}, 32'(win_valid_o),    32'd0);
    check({tag, "_out_row"},   32'(out_row_o),      32'd0);
    check({tag, "_busy"},      32'(busy_o),         32'd0);
    check({tag, "_done"},      32'(frame_done_o),   32'd0);
  endtask

  task automatic load_model();
    win_t w;
    line_q.delete();
    win_q.delete();
    for (int r = 0; r < IM; r++)
      for (int c = 0; c < IM; c++)
        line_q.push_back(r % K);
    for (int orow = 0; orow < NW; orow++)
      for (int col = 0; col < NW; col++) begin
        w.row  = AW'(orow);
        w.addr = AW'(col);
        w.sel  = SW'(orow % K);
        win_q.push_back(w);
      end
    pix_cnt = 0; win_cnt = 0; done_cnt = 0; prev_stall = 1'b0;
  endtask

  task automatic start_frame();
    load_model();
    mon_en = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b1;
    @(posedge clk_i); #1;
    start_i = 1'b0;
    check("ready_after_start", 32'(in_ready_o), 32'd1);
    check("busy_after_start",  32'(busy_o),     32'd1);
  endtask

  task automatic run_frame(input int vpct, input int rpct, input bit noise, input string tag);
    int cyc;
    start_frame();
    cyc = 0;
    while (!frame_done_o && cyc < 20000) begin
      in_valid_i  = ($urandom_range(99) < vpct);
      win_ready_i = ($urandom_range(99) < rpct);
      start_i     = noise && ($urandom_range(9) == 0);
      @(posedge clk_i); #1;
      cyc++;
    end
    start_i = 1'b0; in_valid_i = 1'b0; win_ready_i = 1'b0;
    if (cyc >= 20000) check({tag, "_timeout"}, 32'(cyc), 32'd0);
    @(posedge clk_i); #1;
    @(negedge clk_i); #1;
    check({tag, "_pixels"},   32'(pix_cnt),       32'(IM * IM));
    check({tag, "_windows"},  32'(win_cnt),       32'(NW * NW));
    check({tag, "_done_cnt"}, 32'(done_cnt),      32'd1);
    check({tag, "_lineq"},    32'(line_q.size()), 32'd0);
    check({tag, "_winq"},     32'(win_q.size()),  32'd0);
    check({tag, "_idle"},     32'(busy_o),        32'd0);
    check({tag, "_done_low"}, 32'(frame_done_o),  32'd0);
  endtask

  initial begin
    int cyc;
    // Asynchronous reset state
    #1;
    check_all_zero("reset");
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Idle: pixels offered without start must not be written
    mon_en = 1'b1;
    in_valid_i = 1'b1;
    repeat (4) @(posedge clk_i);
    #1;
    check("idle_busy", 32'(busy_o), 32'd0);
    in_valid_i = 1'b0;
    mon_en = 1'b0;

    // Full-rate frame
    run_frame(100, 100, 1'b0, "full");

    // Reset mid-sweep of output row 1
    start_frame();
    in_valid_i = 1'b1; win_ready_i = 1'b1;
    cyc = 0;
    while (!(win_valid_o && out_row_o == AW'(1) && read_address_o == AW'(5)) && cyc < 5000) begin
      @(posedge clk_i); #1;
      cyc++;
    end
    check("reset_reach_sweep", 32'(win_valid_o), 32'd1);
    mon_en = 1'b0;
    #2 rst_ni = 1'b0;
    #1;
    check_all_zero("midreset");
    in_valid_i = 1'b0; win_ready_i = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check_all_zero("midreset_hold");
    rst_ni = 1'b1;

    // Frame after abort starts again from line 0
    run_frame(100, 100, 1'b0, "after_reset");
    // Backpressure and input gaps with ignored start pulses
    run_frame(70, 70, 1'b1, "bp70");
    run_frame(50, 30, 1'b1, "bp30");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/conv_window_ctrl.md
# conv_window_ctrl

Sequencer for the 3-row pixel line-buffer bank feeding the first convolution layer. Accepts a raster-order pixel stream, steers each row into one of `kernel` line buffers, and, once `kernel` rows are resident, sweeps the shared column read address to present every kernel×kernel window to the MAC array under a valid/ready handshake. One frame per `start_i`; stalls input while sweeping.

## Interface
- `im_dim`, 28, image width = height in pixels.
- `kernel`, 3, window size; equals number of line buffers driven.
- `AW`, `$clog2(im_dim)`, read-address / column-counter width (derived).
- `SW`, `max(1,$clog2(kernel))`, line-select width (derived).

- `clk_i` in 1: single clock, all state on rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `start_i` in 1: begin a frame; sampled only in IDLE.
- `in_valid_i` in 1: pixel available upstream (data routed directly to buffers).
- `in_ready_o` out 1: controller accepting pixels.
- `line_we_o` out kernel: one-hot buffer write enable = `in_valid_i & in_ready_o` on the selected line.
- `read_address_o` out AW: shared column read address to all buffers (leftmost window column).
- `oldest_sel_o` out SW: index of buffer holding the topmost window row.
- `win_valid_o` out 1: current window on buffer outputs is valid.
- `win_ready_i` in 1: downstream consumed window.
- `out_row_o` out AW: output row of current window.
- `busy_o` out 1: high in any state except IDLE.
- `frame_done_o` out 1: one-cycle pulse at end of frame.

## Operation
- States: IDLE, FILL, SWEEP, DONE.
- IDLE: `start_i`=1 → FILL; clear `wr_line`=0, `col`=0, `rows_loaded`=0, `out_row`=0, `oldest_sel`=0.
- FILL: `in_ready_o`=1. Each handshake asserts `line_we_o[wr_line]`, increments `col`. On the handshake with `col`==im_dim−1: `col`←0, `wr_line`←(wr_line+1) mod kernel, `rows_loaded` saturating-increments to kernel; if the new `rows_loaded`==kernel → SWEEP with `read_address`=0, else stay FILL.
- SWEEP: `in_ready_o`=0, `win_valid_o`=1. On `win_ready_i`: if `read_address`==im_dim−kernel, end of row: if `out_row`==im_dim−kernel → DONE; else `out_row`+1, `oldest_sel`←(oldest_sel+1) mod kernel, `read_address`←0, → FILL (overwrite buffer previously holding oldest row; `wr_line` already points there). Otherwise `read_address`+1.
- DONE: `frame_done_o`=1 for exactly one cycle → IDLE.
- `win_valid_o` held with stable `read_address_o`/`oldest_sel_o`/`out_row_o` until `win_ready_i` (no drop while stalled).
- Modulo wrap for `wr_line`, `oldest_sel` is explicit compare-to-(kernel−1), not power-of-two truncation.
- `start_i` outside IDLE ignored. `in_valid_i` outside FILL ignored (no write).

## Timing
- Reset (async, immediate): state=IDLE; all outputs 0 (`in_ready_o`, `line_we_o`, `read_address_o`, `oldest_sel_o`, `win_valid_o`, `out_row_o`, `busy_o`, `frame_done_o`).
- All outputs registered except `line_we_o` (combinational from `in_valid_i`).
- `start_i` at edge n → `in_ready_o`=1 from cycle n+1.
- Buffer read path is combinational: window data valid in the same cycle as `read_address_o`.
- Last fill handshake at edge n → `win_valid_o`=1, `read_address_o`=0 from n+1.
- Per output row: im_dim−kernel+1 windows; frame: (im_dim−kernel+1)² windows (676 at defaults).
- Pixels accepted per frame: im_dim² (784); first kernel·im_dim (84) before first window.
- Reset mid-frame: abort, return to IDLE; partially written buffer contents are don't-care, next frame rewrites from line 0.

## Test plan
- Reset: hold `rst_ni`=0 mid-SWEEP → all outputs 0 asynchronously; release, `start_i` → normal frame from line 0.
- Full frame, `in_valid_i`=1, `win_ready_i`=1 always: exactly 784 pixel handshakes, 676 windows, `frame_done_o` one pulse; `read_address_o` 0..25 per row.
- Line rotation: track `line_we_o` and `oldest_sel_o`: rows 0,1,2 → lines 0,1,2; row 3 → line 0 with `oldest_sel_o`=1; row 4 → line 1, `oldest_sel_o`=2; row 5 → line 2, `oldest_sel_o`=0.
- Backpressure: random `win_ready_i` 30% → `read_address_o`/`win_valid_o` stable while low; window count still 676, no skip/duplicate.
- Input gaps: random `in_valid_i` deassertion in FILL → `line_we_o` only on handshakes; column count per row exactly 28.
- Ignored inputs: `start_i` pulsed during FILL/SWEEP and `in_valid_i`=1 during SWEEP → no state change, `line_we_o`=0.
